wb_arbiter: RTL

- Shares one Wishbone peripheral port between NMASTER controllers, e.g. the SPI-to-Wishbone bridge and a future UART/debug bridge.
- Uses round-robin arbitration with single-transaction grants and registered request forwarding.
- Masks the granted master's stale stb for one cycle after ack, so each transaction is never issued twice.
- Sits between the bridge controllers and the peripheral decoder.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_rr_pick.sv | 32 +++
 rtl/wb_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter state encoding, default bus widths
// and a helper for sizing master-index fields.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } eWbArbState;

    // Default peripheral-bus widths, also used by the SPI bridge.
    localparam int WB_AW = 4;
    localparam int WB_DW = 8;

    // Width of a field that indexes n masters (at least one bit).
    function automatic int wb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// scanning upward from last+1, wrapping modulo NMASTER. The master named by
// 'last' is considered last of all, which gives the rotating priority.
module wb_rr_pick
    import wb_pkg::*;
#(
    parameter int NMASTER = 2,
    parameter int LW      = wb_idx_w(NMASTER)
) (
    input  logic [NMASTER-1:0] req,
    input  logic [LW-1:0]      last,
    output logic               valid,
    output logic [LW-1:0]      grant
);

    int idx;

    // Scan the requesters starting just after the previous grant.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = 0;
        for (int i = 1; i <= NMASTER; i++) begin
            idx = (int'(last) + i) % NMASTER;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx[LW-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: shares one peripheral port between NMASTER
// bridge controllers with single-transaction grants and registered forwarding.
// Optional forced completion of hung transactions: define WB_ARBITER_TIMEOUT_EN.
//
// Handshake: a master raises m_stb with stable we/adr/dat_c and holds it until
// it samples its m_ack bit (one-cycle pulse). The arbiter holds s_stb and s_*
// stable until the peripheral answers with a single-cycle s_ack. The DONE cycle
// after every completion ignores all requests, so the finished master's stb,
// still high while it samples m_ack, is never taken as a new request.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NMASTER = 2,
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NMASTER-1:0]    m_stb,
    input  logic [NMASTER-1:0]    m_we,
    input  logic [NMASTER*AW-1:0] m_adr,
    input  logic [NMASTER*DW-1:0] m_dat_c,
    output logic [NMASTER-1:0]    m_ack,
    output logic [DW-1:0]         m_dat_p,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [AW-1:0]         s_adr,
    output logic [DW-1:0]         s_dat_c,
    input  logic                  s_ack,
    input  logic [DW-1:0]         s_dat_p,
    output logic                  tmo,
    output eWbArbState            dbg_state
);

    localparam int LW = wb_idx_w(NMASTER);
    localparam logic [NMASTER-1:0] ACK_ONE = NMASTER'(1);

    // Reject configurations the arbiter was not designed for.
    if (NMASTER < 1 || NMASTER > 8 || TIMEOUT < 1) begin : g_param_check
        $error("wb_arbiter: NMASTER must be 1..8 and TIMEOUT at least 1");
    end

    eWbArbState    state;
    logic [LW-1:0] last;
    logic [LW-1:0] grant;
    logic          pick_valid;
    logic [LW-1:0] pick_grant;

    assign dbg_state = state;

    wb_rr_pick #(
        .NMASTER (NMASTER),
        .LW      (LW)
    ) u_pick (
        .req   (m_stb),
        .last  (last),
        .valid (pick_valid),
        .grant (pick_grant)
    );

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`else
    assign tmo = 1'b0;
`endif

    // Arbitration FSM: grant in IDLE, forward until ack in BUSY, mask in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= LW'(NMASTER - 1);
            grant   <= '0;
            s_stb   <= 1'b0;
            s_we    <= 1'b0;
            s_adr   <= '0;
            s_dat_c <= '0;
            m_ack   <= '0;
            m_dat_p <= '0;
`ifdef WB_ARBITER_TIMEOUT_EN
            cnt     <= '0;
            tmo     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    m_ack <= '0;
`ifdef WB_ARBITER_TIMEOUT_EN
                    tmo   <= 1'b0;
`endif
                    if (pick_valid) begin
                        grant   <= pick_grant;
                        last    <= pick_grant;
                        s_we    <= m_we[pick_grant];
                        s_adr   <= m_adr[pick_grant*AW +: AW];
                        s_dat_c <= m_dat_c[pick_grant*DW +: DW];
                        s_stb   <= 1'b1;
                        state   <= BUSY;
`ifdef WB_ARBITER_TIMEOUT_EN
                        cnt     <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (s_ack) begin
                        s_stb   <= 1'b0;
                        m_dat_p <= s_dat_p;
                        m_ack   <= ACK_ONE << grant;
                        state   <= DONE;
                    end
`ifdef WB_ARBITER_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT)) begin
                        // Peripheral never answered: complete with all-ones data.
                        s_stb   <= 1'b0;
                        m_dat_p <= {DW{1'b1}};
                        m_ack   <= ACK_ONE << grant;
                        tmo     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    m_ack <= '0;
`ifdef WB_ARBITER_TIMEOUT_EN
                    tmo   <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
